// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle RISC-V controller.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      StRst    = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd6
   } state_e;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_IALU) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait states of an outstanding memory request; flags expiry on the
// TIMEOUT_CYCLES-th consecutive wait cycle.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // cnt_q holds waits already elapsed, so this cycle is the final allowed one.
   assign expired = inc && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: fetch/decode/exec/mem/wb with memory handshakes.
// Define MEM_TIMEOUT_EN to trap on memory requests that wait TIMEOUT_CYCLES cycles.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned STATE_W        = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         Opcode,
   input  logic               zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               ir_write,
   output logic               pc_write,
   output logic               pc_src,
   output logic [1:0]         ALUOp,
   output logic               ALUSrc,
   output logic               Branch,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               retire,
   output logic               trap,
   output logic [STATE_W-1:0] state
);

   state_e     state_q, state_d;
   logic [6:0] opcode_q;
   logic       mem_timeout;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StRst;
         opcode_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StDecode) begin
            opcode_q <= Opcode;
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   mem_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_mem_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_d != state_q),
      .inc    ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)),
      .expired(mem_timeout)
   );
`else
   assign mem_timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = 1'b0;
      ALUOp    = ALUOP_ADD;
      ALUSrc   = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
      trap     = 1'b0;

      unique case (state_q)
         StRst: state_d = StFetch;

         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (mem_timeout) begin
               state_d = StTrap;
            end
         end

         StDecode: state_d = is_legal_op(Opcode) ? StExec : StTrap;

         StExec: begin
            unique case (opcode_q)
               OP_RTYPE: begin
                  ALUOp   = ALUOP_FUNCT;
                  state_d = StWb;
               end
               OP_IALU: begin
                  ALUSrc  = 1'b1;
                  state_d = StWb;
               end
               OP_LOAD, OP_STORE: begin
                  ALUSrc  = 1'b1;
                  state_d = StMem;
               end
               OP_BRANCH: begin
                  ALUOp    = ALUOP_BR;
                  Branch   = 1'b1;
                  pc_write = zero;
                  pc_src   = 1'b1;
                  retire   = 1'b1;
                  state_d  = StFetch;
               end
               default: state_d = StTrap;
            endcase
         end

         StMem: begin
            dmem_req = 1'b1;
            MemRead  = (opcode_q == OP_LOAD);
            MemWrite = (opcode_q == OP_STORE);
            if (dmem_ready) begin
               if (opcode_q == OP_LOAD) begin
                  state_d = StWb;
               end else begin
                  retire  = 1'b1;
                  state_d = StFetch;
               end
            end else if (mem_timeout) begin
               state_d = StTrap;
            end
         end

         StWb: begin
            RegWrite = 1'b1;
            MemtoReg = (opcode_q == OP_LOAD);
            retire   = 1'b1;
            state_d  = StFetch;
         end

         StTrap: trap = 1'b1;

         default: state_d = StTrap;
      endcase
   end

   assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-instruction expected output traces built from the
// opcode-class rules, checked every cycle by one compare process.
module tb_multicycle_controller;

   localparam int unsigned TMO = 16;

   typedef struct packed {
      logic [2:0] st;
      logic       imem_req;
      logic       dmem_req;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic [1:0] aluop;
      logic       alusrc;
      logic       branch;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       retire;
      logic       trap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] Opcode = '0;
   logic       zero = 1'b0;
   logic       imem_ready = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       imem_req, dmem_req, ir_write, pc_write, pc_src;
   logic [1:0] ALUOp;
   logic       ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, retire, trap;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int retire_cnt = 0;
   int dmem_cnt   = 0;
   exp_t exp_q[$];
   logic [2:0] state_log[$];

   multicycle_controller #(
      .TIMEOUT_CYCLES(TMO),
      .STATE_W       (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Opcode    (Opcode),
      .zero      (zero),
      .imem_ready(imem_ready),
      .dmem_ready(dmem_ready),
      .imem_req  (imem_req),
      .dmem_req  (dmem_req),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .pc_src    (pc_src),
      .ALUOp     (ALUOp),
      .ALUSrc    (ALUSrc),
      .Branch    (Branch),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .MemtoReg  (MemtoReg),
      .RegWrite  (RegWrite),
      .retire    (retire),
      .trap      (trap),
      .state     (state)
   );

   always #5 clk = ~clk;

   function automatic exp_t cur();
      return {state, imem_req, dmem_req, ir_write, pc_write, pc_src, ALUOp, ALUSrc,
              Branch, MemRead, MemWrite, MemtoReg, RegWrite, retire, trap};
   endfunction

   function automatic exp_t mk(input logic [2:0] st);
      exp_t e = '0;
      e.st = st;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         state_log.push_back(state);
         if (retire === 1'b1) retire_cnt++;
         if (dmem_req === 1'b1) dmem_cnt++;
      end
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL cycle_outputs @%0t: got %h, expected %h (state got %0d exp %0d)",
                     $time, cur(), e, state, e.st);
         end
      end
   end

   // Called at posedge+1: drive this cycle's inputs and queue its expected outputs.
   task automatic cyc(input exp_t e, input logic ir, input logic dr, input logic z);
      imem_ready = ir;
      dmem_ready = dr;
      zero       = z;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", 32'(cur()), 32'(mk(3'd0)));
      cyc(mk(3'd0), 1'b1, 1'b1, 1'b0);
      cyc(mk(3'd0), 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc(mk(3'd0), 1'b1, 1'b1, 1'b1);
   endtask

   // Stray readies are driven while no request is pending; they must be ignored.
   task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic z,
                            input int rst_in_mem);
      exp_t e;
      logic is_load, is_store, is_br, legal;
      is_load  = (op == 7'b0000011);
      is_store = (op == 7'b0100011);
      is_br    = (op == 7'b1100011);
      legal    = is_load || is_store || is_br || op == 7'b0110011 || op == 7'b0010011;
      Opcode   = op;
      for (int i = 0; i < iw; i++) begin
         e = mk(3'd1);
         e.imem_req = 1'b1;
         cyc(e, 1'b0, 1'b1, z);
      end
      e = mk(3'd1);
      e.imem_req = 1'b1;
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
      cyc(e, 1'b1, 1'b0, z);
      cyc(mk(3'd2), 1'b1, 1'b1, z);
      if (!legal) begin
         for (int i = 0; i < 50; i++) begin
            e = mk(3'd6);
            e.trap = 1'b1;
            cyc(e, 1'b1, 1'b1, z);
         end
         return;
      end
      e = mk(3'd3);
      if (op == 7'b0110011) e.aluop = 2'b10;
      if (op == 7'b0010011 || is_load || is_store) e.alusrc = 1'b1;
      if (is_br) begin
         e.aluop    = 2'b01;
         e.branch   = 1'b1;
         e.pc_write = z;
         e.pc_src   = 1'b1;
         e.retire   = 1'b1;
      end
      cyc(e, 1'b1, 1'b1, z);
      if (is_br) return;
      if (is_load || is_store) begin
         for (int i = 0; i <= dw; i++) begin
            if (i == rst_in_mem) begin
               check("dmem_req_before_rst", 32'(dmem_req), 32'd1);
               apply_reset();
               return;
            end
            e = mk(3'd4);
            e.dmem_req = 1'b1;
            e.memread  = is_load;
            e.memwrite = is_store;
            if (i == dw) begin
               e.retire = is_store;
               cyc(e, 1'b0, 1'b1, z);
            end else begin
               cyc(e, 1'b1, 1'b0, z);
            end
         end
         if (is_store) return;
      end
      e = mk(3'd5);
      e.regwrite = 1'b1;
      e.memtoreg = is_load;
      e.retire   = 1'b1;
      cyc(e, 1'b1, 1'b1, z);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      logic [2:0] want_states [4];
      want_states[0] = 3'd1;
      want_states[1] = 3'd2;
      want_states[2] = 3'd3;
      want_states[3] = 3'd5;

      @(posedge clk);
      #1;
      apply_reset();

      state_log.delete();
      run_instr(7'b0110011, 0, 0, 1'b0, -1);
      check("rtype_state_count", 32'(state_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < state_log.size()) check("rtype_state_seq", 32'(state_log[i]),
                                         32'(want_states[i]));
      end
      check("rtype_retire", 32'(retire_cnt), 32'd1);

      run_instr(7'b0010011, 2, 0, 1'b1, -1);

      d0 = dmem_cnt;
      run_instr(7'b0000011, 0, 3, 1'b0, -1);
      check("load_dmem_req_cycles", 32'(dmem_cnt - d0), 32'd4);

      d0 = dmem_cnt;
      run_instr(7'b0100011, 1, 2, 1'b0, -1);
      check("store_dmem_req_cycles", 32'(dmem_cnt - d0), 32'd3);

      run_instr(7'b1100011, 0, 0, 1'b1, -1);
      run_instr(7'b1100011, 1, 0, 1'b0, -1);
      check("retire_after_six", 32'(retire_cnt), 32'd6);

      run_instr(7'b0000011, 0, 10, 1'b0, 2);
      check("state_after_mid_mem_rst", 32'(state), 32'd1);

      run_instr(7'b1111111, 0, 0, 1'b0, -1);
      check("trap_sticky", 32'(trap), 32'd1);
      apply_reset();
      check("trap_cleared", 32'(trap), 32'd0);

      run_instr(7'b0110011, 3, 0, 1'b0, -1);
      check("retire_total", 32'(retire_cnt), 32'd7);

`ifdef MEM_TIMEOUT_EN
      begin
         exp_t e;
         for (int i = 0; i < int'(TMO); i++) begin
            e = mk(3'd1);
            e.imem_req = 1'b1;
            cyc(e, 1'b0, 1'b1, 1'b0);
         end
         for (int i = 0; i < 4; i++) begin
            e = mk(3'd6);
            e.trap = 1'b1;
            cyc(e, 1'b0, 1'b0, 1'b0);
         end
         check("timeout_trap", 32'(trap), 32'd1);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
